// File: rtl/aq_hpcp_pkg.sv
// Shared definitions for the HPM counter controller: event register layout,
// privilege encodings, FSM state encoding and the default event count.
package aq_hpcp_pkg;

    localparam int EVT_NUM_DEF  = 42;
    localparam int SEL_W        = 6;

    localparam int EVT_OF_BIT   = 63;
    localparam int EVT_MINH_BIT = 62;
    localparam int EVT_SINH_BIT = 61;
    localparam int EVT_UINH_BIT = 60;
    localparam int EVT_SEL_LSB  = 0;
    localparam int EVT_SEL_MSB  = 5;

    typedef enum logic [1:0] {
        PRIV_U = 2'd0,
        PRIV_S = 2'd1,
        PRIV_H = 2'd2,
        PRIV_M = 2'd3
    } priv_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } cnt_state_e;

    // A select code is usable only when it names an implemented event strobe.
    function automatic logic sel_legal(input logic [SEL_W-1:0] sel, input int evt_num);
        return (sel != '0) && (int'(sel) <= evt_num);
    endfunction

endpackage

// File: rtl/aq_hpcp_adder_sel.sv
// Event multiplexer: picks strobe (sel-1); codes outside 1..EVT_NUM return 0.
module aq_hpcp_adder_sel
    import aq_hpcp_pkg::*;
#(
    parameter int EVT_NUM = EVT_NUM_DEF
) (
    input  logic [EVT_NUM-1:0] evt_strb_i,
    input  logic [SEL_W-1:0]   sel_i,
    output logic               strb_o
);

    always_comb begin
        strb_o = 1'b0;
        for (int i = 0; i < EVT_NUM; i++) begin
            if (int'(sel_i) == i + 1) begin
                strb_o = evt_strb_i[i];
            end
        end
    end

endmodule

// File: rtl/aq_hpcp_cnt_ctrl.sv
// Per-counter HPM controller: event select/filter register, qualified strobe
// pipeline, counter with overflow. Optional halt-on-overflow: AQ_HPCP_OVF_INT_EN.
module aq_hpcp_cnt_ctrl
    import aq_hpcp_pkg::*;
#(
    parameter int EVT_NUM   = EVT_NUM_DEF,
    parameter int CNT_WIDTH = 64
) (
    input  logic                 cpuclk,
    input  logic                 cpurst_b,
    input  logic [EVT_NUM-1:0]   evt_strb,
    input  logic [1:0]           cur_priv,
    input  logic                 hpcp_glb_en,
    input  logic                 cnt_inhibit,
    input  logic                 csr_wr_vld,
    input  logic                 csr_wr_sel,
    input  logic [63:0]          csr_wr_data,
    output logic [CNT_WIDTH-1:0] cnt_value,
    output logic [63:0]          evt_value,
    output logic                 cnt_ovf,
    output logic                 cnt_ovf_int
);

    logic [SEL_W-1:0]     sel_q;
    logic                 minh_q, sinh_q, uinh_q;
    logic                 of_q, of_d;
    logic                 inc_vld_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    cnt_state_e           state_q, state_d;

    logic             cnt_wr, evt_wr;
    logic [SEL_W-1:0] wr_sel;
    logic             wr_legal, sel_ok;
    logic             mux_strb, modeinh, hit_p0;
    logic             inc_apply, wrap;
    logic             unused_wr_bits;

    assign cnt_wr   = csr_wr_vld & ~csr_wr_sel;
    assign evt_wr   = csr_wr_vld &  csr_wr_sel;
    assign wr_sel   = csr_wr_data[EVT_SEL_MSB:EVT_SEL_LSB];
    assign wr_legal = sel_legal(wr_sel, EVT_NUM);
    assign sel_ok   = sel_legal(sel_q, EVT_NUM);
    assign unused_wr_bits = ^csr_wr_data[EVT_UINH_BIT-1:EVT_SEL_MSB+1];

    aq_hpcp_adder_sel #(
        .EVT_NUM    (EVT_NUM)
    ) u_adder_sel (
        .evt_strb_i (evt_strb),
        .sel_i      (sel_q),
        .strb_o     (mux_strb)
    );

    // Reserved privilege 2 is filtered with the M-mode inhibit.
    always_comb begin
        case (cur_priv)
            PRIV_U:  modeinh = uinh_q;
            PRIV_S:  modeinh = sinh_q;
            default: modeinh = minh_q;
        endcase
    end

    assign hit_p0 = mux_strb & sel_ok & hpcp_glb_en & ~cnt_inhibit & ~modeinh;

    // A counter write in the same cycle replaces the pending increment.
    assign inc_apply = inc_vld_q & (state_q == ST_RUN) & ~cnt_wr;
    assign wrap      = inc_apply & (&cnt_q);

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_wr) begin
            cnt_d = csr_wr_data[CNT_WIDTH-1:0];
        end else if (inc_apply) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    assign of_d = evt_wr ? csr_wr_data[EVT_OF_BIT] : (of_q | wrap);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (evt_wr && wr_legal) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (evt_wr) state_d = wr_legal ? ST_RUN : ST_IDLE;
`ifdef AQ_HPCP_OVF_INT_EN
                else if (wrap) state_d = ST_HALT;
`endif
            end
            ST_HALT: begin
`ifdef AQ_HPCP_OVF_INT_EN
                if (evt_wr && !csr_wr_data[EVT_OF_BIT]) begin
                    state_d = wr_legal ? ST_RUN : ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stage 1 capture of the qualified strobe; an event write flushes it.
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            sel_q     <= '0;
            minh_q    <= 1'b0;
            sinh_q    <= 1'b0;
            uinh_q    <= 1'b0;
            of_q      <= 1'b0;
            inc_vld_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (evt_wr) begin
                sel_q  <= wr_sel;
                minh_q <= csr_wr_data[EVT_MINH_BIT];
                sinh_q <= csr_wr_data[EVT_SINH_BIT];
                uinh_q <= csr_wr_data[EVT_UINH_BIT];
            end
            of_q      <= of_d;
            inc_vld_q <= evt_wr ? 1'b0 : hit_p0;
            cnt_q     <= cnt_d;
        end
    end

`ifdef AQ_HPCP_OVF_INT_EN
    logic ovf_int_q;

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ovf_int_q <= 1'b0;
        end else begin
            ovf_int_q <= of_q & (state_q == ST_HALT);
        end
    end

    assign cnt_ovf_int = ovf_int_q;
`else
    assign cnt_ovf_int = 1'b0;
`endif

    assign cnt_value = cnt_q;
    assign cnt_ovf   = of_q;
    assign evt_value = {of_q, minh_q, sinh_q, uinh_q,
                        {(EVT_UINH_BIT - EVT_SEL_MSB - 1){1'b0}}, sel_q};

endmodule

// File: tb/tb_aq_hpcp_cnt_ctrl.sv
// Self-checking bench for aq_hpcp_cnt_ctrl: directed scenarios plus randomized
// traffic against a behavioural model. Honours AQ_HPCP_OVF_INT_EN if defined.
module tb_aq_hpcp_cnt_ctrl;

    localparam int EN = 42;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic          cpuclk = 1'b0;
    logic          cpurst_b = 1'b0;
    logic [EN-1:0] evt_strb = '0;
    logic [1:0]    cur_priv = 2'd3;
    logic          hpcp_glb_en = 1'b1;
    logic          cnt_inhibit = 1'b0;
    logic          csr_wr_vld = 1'b0;
    logic          csr_wr_sel = 1'b0;
    logic [63:0]   csr_wr_data = '0;
    logic [63:0]   cnt_value;
    logic [63:0]   evt_value;
    logic          cnt_ovf;
    logic          cnt_ovf_int;

    always #5 cpuclk = ~cpuclk;

    aq_hpcp_cnt_ctrl #(
        .EVT_NUM     (EN),
        .CNT_WIDTH   (64)
    ) dut (
        .cpuclk      (cpuclk),
        .cpurst_b    (cpurst_b),
        .evt_strb    (evt_strb),
        .cur_priv    (cur_priv),
        .hpcp_glb_en (hpcp_glb_en),
        .cnt_inhibit (cnt_inhibit),
        .csr_wr_vld  (csr_wr_vld),
        .csr_wr_sel  (csr_wr_sel),
        .csr_wr_data (csr_wr_data),
        .cnt_value   (cnt_value),
        .evt_value   (evt_value),
        .cnt_ovf     (cnt_ovf),
        .cnt_ovf_int (cnt_ovf_int)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: architectural register contents plus the one strobe
    // that is in flight between qualification and the counter.
    logic [63:0] m_cnt;
    logic [5:0]  m_sel;
    logic        m_of, m_minh, m_sinh, m_uinh;
    logic        m_pend, m_halt, m_int;

    function automatic logic legal(input logic [5:0] s);
        return (s >= 6'd1) && (int'(s) <= EN);
    endfunction

    function automatic logic [EN-1:0] rnd_strb();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[EN-1:0];
    endfunction

    function automatic logic [63:0] m_evt();
        return {m_of, m_minh, m_sinh, m_uinh, 54'd0, m_sel};
    endfunction

    task automatic model_clear();
        m_cnt = '0; m_sel = '0; m_of = 0; m_minh = 0; m_sinh = 0; m_uinh = 0;
        m_pend = 0; m_halt = 0; m_int = 0;
    endtask

    // Drive one cycle of inputs, advance the model, return at posedge+1.
    task automatic cycle(input logic [EN-1:0] s, input logic [1:0] p, input logic g,
                         input logic ih, input logic wv, input logic ws, input logic [63:0] wd);
        logic        pinh, hit, inc, wrap, cw, ew;
        logic [63:0] n_cnt;
        logic        n_of, n_halt, n_int, n_pend;
        evt_strb = s; cur_priv = p; hpcp_glb_en = g; cnt_inhibit = ih;
        csr_wr_vld = wv; csr_wr_sel = ws; csr_wr_data = wd;
        cw = wv && !ws;
        ew = wv && ws;
        pinh = (p == 2'd0) ? m_uinh : (p == 2'd1) ? m_sinh : m_minh;
        hit = 1'b0;
        if (legal(m_sel)) hit = s[m_sel - 6'd1] && g && !ih && !pinh;
        inc = m_pend && legal(m_sel) && !m_halt && !cw;
        wrap = inc && (m_cnt == ALL1);
        n_cnt = cw ? wd : (inc ? m_cnt + 64'd1 : m_cnt);
        n_of = ew ? wd[63] : (m_of || wrap);
        n_pend = ew ? 1'b0 : hit;
`ifdef AQ_HPCP_OVF_INT_EN
        n_int = m_of && m_halt;
        n_halt = ew ? (m_halt && wd[63]) : (m_halt || wrap);
`else
        n_int = 1'b0;
        n_halt = 1'b0;
`endif
        @(posedge cpuclk);
        #1;
        m_cnt = n_cnt; m_of = n_of; m_pend = n_pend; m_int = n_int; m_halt = n_halt;
        if (ew) begin
            m_sel = wd[5:0]; m_minh = wd[62]; m_sinh = wd[61]; m_uinh = wd[60];
        end
        csr_wr_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    endtask

    task automatic wr_cnt(input logic [63:0] v);
        cycle('0, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, v);
    endtask

    task automatic wr_evt(input logic [63:0] v);
        cycle('0, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, v);
    endtask

    task automatic test_reset();
        cpurst_b = 1'b0;
        model_clear();
        repeat (2) @(posedge cpuclk);
        #1;
        n_total++; if (cnt_value !== 64'd0) $display("FAIL reset_cnt got %0h want 0", cnt_value); else n_pass++;
        n_total++; if (evt_value !== 64'd0) $display("FAIL reset_evt got %0h want 0", evt_value); else n_pass++;
        n_total++; if (cnt_ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", cnt_ovf); else n_pass++;
        n_total++; if (cnt_ovf_int !== 1'b0) $display("FAIL reset_int got %b want 0", cnt_ovf_int); else n_pass++;
        cpurst_b = 1'b1;
        idle(2);
    endtask

    task automatic test_basic_count();
        logic [63:0] exp_seq [5];
        logic [EN-1:0] s;
        exp_seq = '{64'd0, 64'd1, 64'd2, 64'd3, 64'd3};
        wr_evt(64'd5);
        n_total++; if (evt_value !== 64'd5) $display("FAIL basic_evt got %0h want 5", evt_value); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            s = rnd_strb();
            s[4] = (i < 3);
            cycle(s, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
            n_total++;
            if (cnt_value !== exp_seq[i]) $display("FAIL basic_cnt[%0d] got %0h want %0h", i, cnt_value, exp_seq[i]);
            else n_pass++;
        end
    endtask

    task automatic test_illegal_sel();
        logic ok;
        wr_cnt(64'd0);
        wr_evt(64'd0);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle((i % 2 == 0) ? {EN{1'b1}} : rnd_strb(), 2'(i % 4), 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
            if (cnt_value !== 64'd0) ok = 1'b0;
        end
        n_total++; if (!ok) $display("FAIL sel0_cnt got %0h want 0", cnt_value); else n_pass++;
        wr_evt(64'd50);
        n_total++; if (evt_value !== 64'd50) $display("FAIL sel50_evt got %0h want 32", evt_value); else n_pass++;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle({EN{1'b1}}, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
            if (cnt_value !== 64'd0) ok = 1'b0;
        end
        n_total++; if (!ok) $display("FAIL sel50_cnt got %0h want 0", cnt_value); else n_pass++;
    endtask

    task automatic test_priv_filter();
        logic [63:0] ev;
        ev = (64'd1 << 60) | 64'd3;
        wr_cnt(64'd0);
        wr_evt(ev);
        n_total++; if (evt_value !== ev) $display("FAIL priv_evt got %0h want %0h", evt_value, ev); else n_pass++;
        for (int i = 0; i < 4; i++) cycle(EN'(4), 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        idle(2);
        n_total++; if (cnt_value !== 64'd0) $display("FAIL priv_u_cnt got %0h want 0", cnt_value); else n_pass++;
        for (int i = 0; i < 4; i++) cycle(EN'(4), 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        idle(2);
        n_total++; if (cnt_value !== 64'd4) $display("FAIL priv_m_cnt got %0h want 4", cnt_value); else n_pass++;
        for (int i = 0; i < 3; i++) cycle(EN'(4), 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        idle(2);
        n_total++; if (cnt_value !== 64'd7) $display("FAIL priv_h_cnt got %0h want 7", cnt_value); else n_pass++;
    endtask

    task automatic test_cnt_write_collision();
        wr_evt(64'd5);
        wr_cnt(64'd0);
        cycle(EN'(1) << 4, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        cycle('0, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 64'h100);
        n_total++; if (cnt_value !== 64'h100) $display("FAIL wrwin_cnt got %0h want 100", cnt_value); else n_pass++;
        idle(1);
        n_total++; if (cnt_value !== 64'h100) $display("FAIL wrwin_hold got %0h want 100", cnt_value); else n_pass++;
        cycle(EN'(1) << 4, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        cycle(EN'(1) << 4, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 64'h100);
        n_total++; if (cnt_value !== 64'h100) $display("FAIL wrhit_cnt got %0h want 100", cnt_value); else n_pass++;
        idle(1);
        n_total++; if (cnt_value !== 64'h101) $display("FAIL wrhit_next got %0h want 101", cnt_value); else n_pass++;
    endtask

    task automatic test_wrap();
        wr_evt(64'd5);
        wr_cnt(ALL1);
        cycle(EN'(1) << 4, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        idle(1);
        n_total++; if (cnt_value !== 64'd0) $display("FAIL wrap_cnt got %0h want 0", cnt_value); else n_pass++;
        n_total++; if (cnt_ovf !== 1'b1) $display("FAIL wrap_ovf got %b want 1", cnt_ovf); else n_pass++;
        n_total++; if (evt_value[63] !== 1'b1) $display("FAIL wrap_of_bit got %b want 1", evt_value[63]); else n_pass++;
`ifdef AQ_HPCP_OVF_INT_EN
        idle(1);
        n_total++; if (cnt_ovf_int !== 1'b1) $display("FAIL wrap_int got %b want 1", cnt_ovf_int); else n_pass++;
        cycle(EN'(1) << 4, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        idle(2);
        n_total++; if (cnt_value !== 64'd0) $display("FAIL halt_cnt got %0h want 0", cnt_value); else n_pass++;
        n_total++; if (cnt_ovf_int !== 1'b1) $display("FAIL halt_int got %b want 1", cnt_ovf_int); else n_pass++;
        wr_evt(64'd5);
        n_total++; if (cnt_ovf !== 1'b0) $display("FAIL clr_ovf got %b want 0", cnt_ovf); else n_pass++;
        idle(1);
        n_total++; if (cnt_ovf_int !== 1'b0) $display("FAIL clr_int got %b want 0", cnt_ovf_int); else n_pass++;
        cycle(EN'(1) << 4, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        idle(1);
        n_total++; if (cnt_value !== 64'd1) $display("FAIL resume_cnt got %0h want 1", cnt_value); else n_pass++;
`else
        cycle(EN'(1) << 4, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        idle(1);
        n_total++; if (cnt_value !== 64'd1) $display("FAIL resume_cnt got %0h want 1", cnt_value); else n_pass++;
        n_total++; if (cnt_ovf !== 1'b1) $display("FAIL sticky_ovf got %b want 1", cnt_ovf); else n_pass++;
        n_total++; if (cnt_ovf_int !== 1'b0) $display("FAIL noint got %b want 0", cnt_ovf_int); else n_pass++;
        wr_evt(64'd5);
`endif
        wr_cnt(ALL1);
        cycle(EN'(1) << 4, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        wr_evt(64'd5);
        n_total++; if (cnt_value !== 64'd0) $display("FAIL ovr_cnt got %0h want 0", cnt_value); else n_pass++;
        n_total++; if (cnt_ovf !== 1'b0) $display("FAIL ovr_ovf got %b want 0", cnt_ovf); else n_pass++;
        idle(1);
        n_total++; if (cnt_ovf_int !== 1'b0) $display("FAIL ovr_int got %b want 0", cnt_ovf_int); else n_pass++;
    endtask

    task automatic test_random();
        logic [63:0] wd;
        logic        wv, ws;
        int          bad;
        bad = 0;
        wr_evt(64'd7);
        for (int i = 0; i < 600; i++) begin
            wv = ($urandom_range(0, 11) == 0);
            ws = $urandom_range(0, 1) != 0;
            wd = {$urandom, $urandom};
            if (ws) begin
                wd[5:0] = 6'($urandom_range(0, 47));
                wd[63]  = ($urandom_range(0, 3) == 0);
                wd[62:60] = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            end else if ($urandom_range(0, 1) != 0) begin
                wd = ALL1 - 64'($urandom_range(0, 6));
            end
            cycle(rnd_strb(), 2'($urandom_range(0, 3)), $urandom_range(0, 7) != 0,
                  $urandom_range(0, 7) == 0, wv, ws, wd);
            n_total++;
            if (cnt_value !== m_cnt || evt_value !== m_evt() || cnt_ovf !== m_of || cnt_ovf_int !== m_int) begin
                if (bad < 5)
                    $display("FAIL rand[%0d] got cnt=%0h evt=%0h ovf=%b int=%b want cnt=%0h evt=%0h ovf=%b int=%b",
                             i, cnt_value, evt_value, cnt_ovf, cnt_ovf_int, m_cnt, m_evt(), m_of, m_int);
                bad++;
            end else n_pass++;
        end
    endtask

    task automatic test_reset_midstream();
        wr_evt(64'd5);
        wr_cnt(64'h55);
        cycle(EN'(1) << 4, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        #3;
        cpurst_b = 1'b0;
        model_clear();
        #1;
        n_total++; if (cnt_value !== 64'd0) $display("FAIL arst_cnt got %0h want 0", cnt_value); else n_pass++;
        n_total++; if (evt_value !== 64'd0) $display("FAIL arst_evt got %0h want 0", evt_value); else n_pass++;
        n_total++; if (cnt_ovf !== 1'b0 || cnt_ovf_int !== 1'b0)
            $display("FAIL arst_flags got ovf=%b int=%b want 0 0", cnt_ovf, cnt_ovf_int); else n_pass++;
        @(posedge cpuclk);
        #1;
        cpurst_b = 1'b1;
        wr_evt(64'd5);
        idle(3);
        n_total++; if (cnt_value !== 64'd0) $display("FAIL arst_lost got %0h want 0", cnt_value); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_illegal_sel();
        test_priv_filter();
        test_cnt_write_collision();
        test_wrap();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
